// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for the two-input logic-gate block: walks a/b through all
// four combinations, captures the 7-bit response per vector and checks it against golden values.
module gate_sweep_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a_out,
  output logic        b_out,
  input  logic [6:0]  y_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [6:0]  err_vec,
  output logic        fail_seen,
  output logic [1:0]  fail_idx,
  output logic [27:0] table_out
);

  // start is a level request with no ready: it is accepted only on a cycle the
  // FSM is in IDLE; any level seen while busy is dropped, not queued.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [6:0]  err_q, err_d;
  logic        fs_q, fs_d;
  logic [1:0]  fi_q, fi_d;
  logic [27:0] tbl_q, tbl_d;
  logic [6:0]  mism;

  function automatic logic [6:0] golden(input logic [1:0] k);
    case (k)
      2'd0:    golden = 7'h1D;
      2'd1:    golden = 7'h3A;
      2'd2:    golden = 7'h2A;
      default: golden = 7'h61;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 7'd0;
      fs_q    <= 1'b0;
      fi_q    <= 2'd0;
      tbl_q   <= 28'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fs_q    <= fs_d;
      fi_q    <= fi_d;
      tbl_q   <= tbl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fs_d    = fs_q;
    fi_d    = fi_q;
    tbl_d   = tbl_q;
    mism    = y_in ^ golden(k_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          k_d     = 2'd0;
          cnt_d   = 4'd0;
          pass_d  = 1'b0;
          err_d   = 7'd0;
          fs_d    = 1'b0;
          fi_d    = 2'd0;
          tbl_d   = 28'd0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_CNT) state_d = S_SAMPLE;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      S_SAMPLE: begin
        case (k_q)
          2'd0:    tbl_d[6:0]   = y_in;
          2'd1:    tbl_d[13:7]  = y_in;
          2'd2:    tbl_d[20:14] = y_in;
          default: tbl_d[27:21] = y_in;
        endcase
        err_d = err_q | mism;
        if (mism != 7'd0 && !fs_q) begin
          fs_d = 1'b1;
          fi_d = k_q;
        end
        // pass is decided here so it is already valid in the FINISH cycle with done.
        if (k_q == 2'd3) begin
          state_d = S_FINISH;
          pass_d  = (err_d == 7'd0);
        end else begin
          state_d = S_SETTLE;
          k_d     = k_q + 2'd1;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  assign a_out     = k_q[1];
  assign b_out     = k_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_vec   = err_q;
  assign fail_seen = fs_q;
  assign fail_idx  = fi_q;
  assign table_out = tbl_q;

endmodule
